// File: rtl/parity_stream_encoder.sv
// Streaming parity encoder: per-word even/odd parity plus frame parity over FRAME_LEN words,
// behind a single registered valid/ready stage. Define PARITY_CHECK_EN to add received-parity checking.
module parity_stream_encoder #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              odd_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par,
    output logic              out_last,
    output logic              frame_par
`ifdef PARITY_CHECK_EN
    ,
    input  logic              in_par,
    output logic              par_err,
    output logic              err_sticky
`endif
);

    localparam int CNT_W = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                acc_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_par_q;
    logic                out_last_q;
    logic                frame_par_q;

    logic                accept;
    logic                word_par;
    logic                is_last;
    logic                acc_d;
    logic [CNT_W-1:0]    cnt_d;
    state_t              state_d;

    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign word_par = ^in_data;
    assign is_last  = (cnt_q == LAST_CNT);

    // Frame bookkeeping: the accumulator restarts from the word itself on word0.
    always_comb begin
        acc_d   = (state_q == IDLE) ? word_par : (acc_q ^ word_par);
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ACCUM;
        if (is_last) begin
            cnt_d   = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_par_q   <= 1'b0;
            out_last_q  <= 1'b0;
            frame_par_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data;
            out_par_q   <= word_par ^ odd_sel;
            out_last_q  <= is_last;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= is_last ? 1'b0 : acc_d;
            if (is_last) begin
                frame_par_q <= acc_d ^ odd_sel;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_par   = out_par_q;
    assign out_last  = out_last_q;
    assign frame_par = frame_par_q;

`ifdef PARITY_CHECK_EN
    logic par_err_q;
    logic err_sticky_q;
    logic par_err_d;

    assign par_err_d = in_par != (word_par ^ odd_sel);

    // Error flag travels with the word; the sticky copy only clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else if (accept) begin
            par_err_q <= par_err_d;
            if (par_err_d) begin
                err_sticky_q <= 1'b1;
            end
        end
    end

    assign par_err    = par_err_q;
    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_parity_stream_encoder.sv
// Directed bench for parity_stream_encoder (DATA_W=8, FRAME_LEN=4) with a scoreboard of expected output words.
module tb_parity_stream_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       odd_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_par;
    logic       out_last;
    logic       frame_par;
`ifdef PARITY_CHECK_EN
    logic       in_par;
    logic       par_err;
    logic       err_sticky;
    logic       inj_err = 1'b0;
`endif

    parity_stream_encoder #(.DATA_W(8), .FRAME_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .odd_sel   (odd_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_par   (out_par),
        .out_last  (out_last),
        .frame_par (frame_par)
`ifdef PARITY_CHECK_EN
        ,
        .in_par    (in_par),
        .par_err   (par_err),
        .err_sticky(err_sticky)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       l;
        logic       fp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    int   m_cnt  = 0;
    logic m_acc  = 1'b0;
    logic m_fp   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] d, input logic o);
        exp_t e;
        logic wp;
        wp    = ^d;
        m_acc = (m_cnt == 0) ? wp : (m_acc ^ wp);
        e.d   = d;
        e.p   = wp ^ o;
        e.l   = (m_cnt == 3);
        if (e.l) begin
            m_fp  = m_acc ^ o;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        e.fp = m_fp;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_acc = 1'b0;
        m_fp  = 1'b0;
        sb.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after the word was accepted.
    task automatic send(input logic [7:0] d, input logic o);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        odd_sel  = o;
`ifdef PARITY_CHECK_EN
        in_par   = (^d) ^ o ^ inj_err;
`endif
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        model_push(d, o);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'(d));
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("extra_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_data", 32'(out_data), 32'(mon_e.d));
                chk("sb_par", 32'(out_par), 32'(mon_e.p));
                chk("sb_last", 32'(out_last), 32'(mon_e.l));
                chk("sb_frame_par", 32'(frame_par), 32'(mon_e.fp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        odd_sel   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
`ifdef PARITY_CHECK_EN
        in_par    = 1'b0;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_par", 32'(out_par), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_frame_par", 32'(frame_par), 0);
`ifdef PARITY_CHECK_EN
        chk("rst_par_err", 32'(par_err), 0);
        chk("rst_err_sticky", 32'(err_sticky), 0);
`endif
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Per-word parity, even then odd
        send(8'h01, 1'b0);
        chk("t2_par_01_even", 32'(out_par), 1);
        send(8'h03, 1'b0);
        chk("t2_par_03_even", 32'(out_par), 0);
        send(8'h03, 1'b1);
        chk("t2_par_03_odd", 32'(out_par), 1);

        // Fresh frame
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        send(8'h01, 1'b0);
        chk("t3_last_w0", 32'(out_last), 0);
        send(8'h02, 1'b0);
        chk("t3_last_w1", 32'(out_last), 0);
        send(8'h04, 1'b0);
        chk("t3_last_w2", 32'(out_last), 0);
        send(8'h00, 1'b0);
        chk("t3_last_w3", 32'(out_last), 1);
        chk("t3_frame_par", 32'(frame_par), 1);
        send(8'hFF, 1'b0);
        chk("t3_wrap_last", 32'(out_last), 0);
        chk("t3_frame_par_hold", 32'(frame_par), 1);

        // Backpressure: hold 0x11 while 0xA5 waits
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        send(8'h11, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        odd_sel  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_in_ready_stall", 32'(in_ready), 0);
            chk("t4_out_data_hold", 32'(out_data), 'h11);
            chk("t4_out_valid_hold", 32'(out_valid), 1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        send(8'hA5, 1'b0);
        chk("t4_out_data_next", 32'(out_data), 'hA5);
        send(8'h5A, 1'b1);
        send(8'h80, 1'b0);

        // Reset mid-frame
        send(8'h07, 1'b0);
        send(8'h0F, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_in_ready", 32'(in_ready), 0);
        chk("t5_rst_out_valid", 32'(out_valid), 0);
        chk("t5_rst_frame_par", 32'(frame_par), 0);
        model_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        chk("t5_last_w2", 32'(out_last), 0);
        send(8'h01, 1'b0);
        chk("t5_last_w3", 32'(out_last), 1);
        chk("t5_frame_par", 32'(frame_par), 0);

`ifdef PARITY_CHECK_EN
        inj_err = 1'b1;
        send(8'h01, 1'b0);
        chk("t6_par_err_bad", 32'(par_err), 1);
        chk("t6_sticky_bad", 32'(err_sticky), 1);
        inj_err = 1'b0;
        send(8'h03, 1'b0);
        chk("t6_par_err_good", 32'(par_err), 0);
        chk("t6_sticky_held", 32'(err_sticky), 1);
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("idle_out_valid", 32'(out_valid), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
